// File: rtl/sysid_pkg.sv
// System ID block: register offsets, CAPS layout
// and a byte-lane merge helper shared by the RTL.
package sysid_pkg;

  localparam logic [3:0] ADDR_ID      = 4'd0;
  localparam logic [3:0] ADDR_TS      = 4'd1;
  localparam logic [3:0] ADDR_UP_LO   = 4'd2;
  localparam logic [3:0] ADDR_UP_HI   = 4'd3;
  localparam logic [3:0] ADDR_SCRATCH = 4'd4;
  localparam logic [3:0] ADDR_CAPS    = 4'd5;

  localparam logic [15:0] CAPS_VERSION = 16'h0002;
  localparam int CAPS_VER_LSB = 16;
  localparam int CAPS_ERR_BIT = 12;
  localparam int CAPS_LAT_LSB = 8;
  localparam int CAPS_NUM_LSB = 0;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sysid_rd_pipe.sv
// Valid+data delay line stretching the read path
// to the configured latency; flush drops all in flight.
module sysid_rd_pipe #(
  parameter int DEPTH = 1
) (
  input  logic        clock,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clock, flush};
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] v;
    logic [31:0]      d [DEPTH];

    always_ff @(posedge clock) begin
      if (flush) begin
        v <= '0;
        for (int i = 0; i < DEPTH; i++)
          d[i] <= '0;
      end else begin
        v[0] <= in_valid;
        d[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
        end
      end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
  end

endmodule

// File: rtl/sysid_ext.sv
// Avalon-MM system ID / uptime / scratch register block
// with configurable read latency and user constant words.
module sysid_ext
  import sysid_pkg::*;
#(
  parameter logic [31:0]  SYS_ID         = 32'h0000_0000,
  parameter logic [31:0]  TIMESTAMP      = 32'd0,
  parameter int           NUM_USER_WORDS = 4,
  parameter logic [255:0] USER_DATA      = '0,
  parameter int           READ_LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [63:0] uptime;
  logic [31:0] up_hi_shadow;
  logic [31:0] scratch;
  logic        err_sticky;

  logic        rd_go;
  logic        user_hit;
  logic [2:0]  user_idx;
  logic [31:0] caps;
  logic [31:0] rd_word;
  logic        v0;
  logic [31:0] d0;
  logic        flush;

  // A simultaneous write wins; the read is dropped.
  assign rd_go    = read & ~write;
  assign user_idx = address[2:0];
  assign user_hit = address[3] &&
                    (int'(user_idx) < NUM_USER_WORDS);
  assign flush    = ~reset_n;

  always_comb begin
    caps = '0;
    caps[CAPS_VER_LSB +: 16] = CAPS_VERSION;
    caps[CAPS_ERR_BIT]       = err_sticky;
    caps[CAPS_LAT_LSB +: 4]  = 4'(READ_LATENCY);
    caps[CAPS_NUM_LSB +: 8]  = 8'(NUM_USER_WORDS);
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      (address == ADDR_ID):      rd_word = SYS_ID;
      (address == ADDR_TS):      rd_word = TIMESTAMP;
      (address == ADDR_UP_LO):   rd_word = uptime[31:0];
      (address == ADDR_UP_HI):   rd_word = up_hi_shadow;
      (address == ADDR_SCRATCH): rd_word = scratch;
      (address == ADDR_CAPS):    rd_word = caps;
      user_hit:                  rd_word = USER_DATA[{user_idx, 5'b0} +: 32];
      default:                   rd_word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      uptime       <= '0;
      up_hi_shadow <= '0;
      scratch      <= '0;
      err_sticky   <= 1'b0;
      v0           <= 1'b0;
      d0           <= '0;
    end else begin
      uptime <= uptime + 64'd1;
      if (write) begin
        if (address == ADDR_SCRATCH) begin
          scratch <= byte_merge(scratch, writedata, byteenable);
          if (byteenable[3] && writedata[31])
            err_sticky <= 1'b0;
        end else begin
          err_sticky <= 1'b1;
        end
      end
      if (rd_go && address == ADDR_UP_LO)
        up_hi_shadow <= uptime[63:32];
      v0 <= rd_go;
      d0 <= rd_go ? rd_word : '0;
    end
  end

  sysid_rd_pipe #(
    .DEPTH (READ_LATENCY - 1)
  ) u_rd_pipe (
    .clock     (clock),
    .flush     (flush),
    .in_valid  (v0),
    .in_data   (d0),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_sysid_ext.sv
// Directed bench for sysid_ext: latency, uptime snapshot,
// scratch byte lanes, error flag, map holes and reset flush.
module tb_sysid_ext;

  localparam logic [31:0] SID = 32'h5A23_D9CF;
  localparam logic [31:0] TS  = 32'd1512262351;
  localparam logic [255:0] UD = {
    32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005, 32'hC0DE_0004,
    32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
  localparam logic [31:0] CAPS_OK  = 32'h0002_0204;
  localparam logic [31:0] CAPS_ERR = 32'h0002_1204;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  sysid_ext #(
    .SYS_ID         (SID),
    .TIMESTAMP      (TS),
    .NUM_USER_WORDS (4),
    .USER_DATA      (UD),
    .READ_LATENCY   (2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  task automatic idle();
    read = 1'b0;
    write = 1'b0;
    address = '0;
    writedata = '0;
    byteenable = '0;
  endtask

  task automatic do_write(input logic [3:0] a,
                          input logic [31:0] d,
                          input logic [3:0] be);
    address = a;
    writedata = d;
    byteenable = be;
    write = 1'b1;
    read = 1'b0;
    @(negedge clock);
    idle();
  endtask

  // Issues one read and waits (bounded) for its valid pulse.
  task automatic do_read(input logic [3:0] a,
                         output logic [31:0] d,
                         output int lat);
    address = a;
    read = 1'b1;
    write = 1'b0;
    @(negedge clock);
    idle();
    lat = -1;
    d = '0;
    for (int i = 1; i <= 8; i++) begin
      if (readdatavalid) begin
        lat = i;
        d = readdata;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    reset_n = 1'b0;
    read = 1'b1;
    address = 4'd0;
    repeat (2) @(negedge clock);
    total++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_out_a got v=%b d=%h want v=0 d=0",
               readdatavalid, readdata);
    end
    read = 1'b0;
    write = 1'b1;
    writedata = 32'hFFFF_FFFF;
    byteenable = 4'hF;
    @(negedge clock);
    address = 4'd4;
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_out_b got v=%b d=%h want v=0 d=0",
               readdatavalid, readdata);
    end
    idle();
    reset_n = 1'b1;
    do_read(4'd2, d, lat);
    total++;
    if (lat != 2 || d !== 32'h0) begin
      bad++;
      $display("FAIL reset_uptime got lat=%0d d=%h want lat=2 d=0", lat, d);
    end
    do_read(4'd5, d, lat);
    total++;
    if (lat != 2 || d !== CAPS_OK) begin
      bad++;
      $display("FAIL reset_caps got lat=%0d d=%h want %h", lat, d, CAPS_OK);
    end
    do_read(4'd4, d, lat);
    total++;
    if (lat != 2 || d !== 32'h0) begin
      bad++;
      $display("FAIL reset_scratch got lat=%0d d=%h want 0", lat, d);
    end
  endtask

  task automatic test_back_to_back();
    address = 4'd0;
    read = 1'b1;
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_early got v=%b want v=0", readdatavalid);
    end
    address = 4'd1;
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b1 || readdata !== SID) begin
      bad++;
      $display("FAIL b2b_id got v=%b d=%h want v=1 d=%h",
               readdatavalid, readdata, SID);
    end
    address = 4'd5;
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b1 || readdata !== TS) begin
      bad++;
      $display("FAIL b2b_ts got v=%b d=%h want v=1 d=%h",
               readdatavalid, readdata, TS);
    end
    idle();
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b1 || readdata !== CAPS_OK) begin
      bad++;
      $display("FAIL b2b_caps got v=%b d=%h want v=1 d=%h",
               readdatavalid, readdata, CAPS_OK);
    end
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      bad++;
      $display("FAIL b2b_tail got v=%b d=%h want v=0 d=0",
               readdatavalid, readdata);
    end
  endtask

  task automatic test_uptime_snap();
    logic [31:0] d;
    int lat;
    force dut.uptime = 64'h0000_0001_FFFF_FFFF;
    address = 4'd2;
    read = 1'b1;
    @(negedge clock);
    release dut.uptime;
    address = 4'd3;
    @(negedge clock);
    idle();
    total++;
    if (readdatavalid !== 1'b1 || readdata !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL snap_lo got v=%b d=%h want v=1 d=ffffffff",
               readdatavalid, readdata);
    end
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b1 || readdata !== 32'h0000_0001) begin
      bad++;
      $display("FAIL snap_hi got v=%b d=%h want v=1 d=00000001",
               readdatavalid, readdata);
    end
    do_write(4'd4, 32'h1234_5678, 4'h0);
    do_read(4'd3, d, lat);
    total++;
    if (lat != 2 || d !== 32'h0000_0001) begin
      bad++;
      $display("FAIL snap_hold got lat=%0d d=%h want 00000001", lat, d);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    int lat;
    int seen;
    do_write(4'd4, 32'hDEAD_BEEF, 4'hF);
    do_write(4'd4, 32'h1122_3344, 4'b0101);
    do_read(4'd4, d, lat);
    total++;
    if (lat != 2 || d !== 32'hDE22_BE44) begin
      bad++;
      $display("FAIL scratch_be got lat=%0d d=%h want de22be44", lat, d);
    end
    address = 4'd4;
    read = 1'b1;
    write = 1'b1;
    writedata = 32'h0000_0055;
    byteenable = 4'h1;
    @(negedge clock);
    idle();
    seen = 0;
    repeat (4) begin
      if (readdatavalid) seen++;
      @(negedge clock);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rw_collide got pulses=%0d want 0", seen);
    end
    do_read(4'd4, d, lat);
    total++;
    if (lat != 2 || d !== 32'hDE22_BE55) begin
      bad++;
      $display("FAIL rw_write got lat=%0d d=%h want de22be55", lat, d);
    end
  endtask

  task automatic test_err();
    logic [31:0] d;
    int lat;
    do_write(4'd0, 32'hFFFF_FFFF, 4'hF);
    do_read(4'd0, d, lat);
    total++;
    if (lat != 2 || d !== SID) begin
      bad++;
      $display("FAIL err_id_kept got lat=%0d d=%h want %h", lat, d, SID);
    end
    do_read(4'd5, d, lat);
    total++;
    if (lat != 2 || d !== CAPS_ERR) begin
      bad++;
      $display("FAIL err_set got lat=%0d d=%h want %h", lat, d, CAPS_ERR);
    end
    do_write(4'd4, 32'h8000_0000, 4'h7);
    do_read(4'd5, d, lat);
    total++;
    if (lat != 2 || d !== CAPS_ERR) begin
      bad++;
      $display("FAIL err_no_be3 got lat=%0d d=%h want %h", lat, d, CAPS_ERR);
    end
    do_read(4'd4, d, lat);
    total++;
    if (lat != 2 || d !== 32'hDE00_0000) begin
      bad++;
      $display("FAIL err_scr_lo got lat=%0d d=%h want de000000", lat, d);
    end
    do_write(4'd4, 32'h8000_0000, 4'h8);
    do_read(4'd5, d, lat);
    total++;
    if (lat != 2 || d !== CAPS_OK) begin
      bad++;
      $display("FAIL err_clear got lat=%0d d=%h want %h", lat, d, CAPS_OK);
    end
    do_read(4'd4, d, lat);
    total++;
    if (lat != 2 || d !== 32'h8000_0000) begin
      bad++;
      $display("FAIL err_scr_hi got lat=%0d d=%h want 80000000", lat, d);
    end
    do_write(4'd7, 32'h0, 4'hF);
    do_read(4'd5, d, lat);
    total++;
    if (lat != 2 || d !== CAPS_ERR) begin
      bad++;
      $display("FAIL err_rsvd got lat=%0d d=%h want %h", lat, d, CAPS_ERR);
    end
  endtask

  task automatic test_map();
    logic [3:0]  addrs [7];
    logic [31:0] exps  [7];
    logic [31:0] d;
    int lat;
    addrs = '{4'd1, 4'd6, 4'd7, 4'd8, 4'd11, 4'd12, 4'd15};
    exps  = '{TS, 32'h0, 32'h0, 32'hC0DE_0000, 32'hC0DE_0003,
              32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      do_read(addrs[i], d, lat);
      total++;
      if (lat != 2 || d !== exps[i]) begin
        bad++;
        $display("FAIL map_w%0d got lat=%0d d=%h want %h",
                 addrs[i], lat, d, exps[i]);
      end
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] d;
    int lat;
    address = 4'd0;
    read = 1'b1;
    @(negedge clock);
    address = 4'd1;
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b1 || readdata !== SID) begin
      bad++;
      $display("FAIL flush_pre0 got v=%b d=%h want v=1 d=%h",
               readdatavalid, readdata, SID);
    end
    address = 4'd5;
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b1 || readdata !== TS) begin
      bad++;
      $display("FAIL flush_pre1 got v=%b d=%h want v=1 d=%h",
               readdatavalid, readdata, TS);
    end
    idle();
    reset_n = 1'b0;
    @(negedge clock);
    total++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      bad++;
      $display("FAIL flush_drop got v=%b d=%h want v=0 d=0",
               readdatavalid, readdata);
    end
    reset_n = 1'b1;
    do_read(4'd2, d, lat);
    total++;
    if (lat != 2 || d !== 32'h0) begin
      bad++;
      $display("FAIL flush_uptime got lat=%0d d=%h want lat=2 d=0", lat, d);
    end
    do_read(4'd5, d, lat);
    total++;
    if (lat != 2 || d !== CAPS_OK) begin
      bad++;
      $display("FAIL flush_caps got lat=%0d d=%h want %h", lat, d, CAPS_OK);
    end
    do_read(4'd4, d, lat);
    total++;
    if (lat != 2 || d !== 32'h0) begin
      bad++;
      $display("FAIL flush_scratch got lat=%0d d=%h want 0", lat, d);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_uptime_snap();
    test_scratch();
    test_err();
    test_map();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
